mem_ctrl: RTL
=============

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 2, meaning the address width; depth SHALL be 2**ADDR_WIDTH entries.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning the word width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 addr  input  ADDR_WIDTH  request address for read and write.
REQ-007 wr_en  input  1  write request qualifier.
REQ-008 rd_en  input  1  read request qualifier.
REQ-009 wdata  input  DATA_WIDTH  write data.
REQ-010 rdata  output  DATA_WIDTH  registered read data.
REQ-011 rd_valid  output  1  one-cycle pulse marking rdata as new read data.
REQ-012 rd_err  output  1  qualified by rd_valid; the entry read had not been written since reset.
REQ-013 busy  output  1  high while initialising; requests SHALL be ignored while high.
REQ-014 wr_cnt  output  8  saturating count of accepted writes.
REQ-015 rd_cnt  output  8  saturating count of accepted reads.

Function
REQ-016 The FSM SHALL have exactly two states: INIT and IDLE.
REQ-017 INIT SHALL last exactly 2**ADDR_WIDTH cycles, clearing one entry per cycle to 0 in address order 0..DEPTH-1 and clearing its written flag; it then SHALL move to IDLE.
REQ-018 busy SHALL be 1 exactly while in INIT.
REQ-019 wr_en, rd_en, addr and wdata SHALL be ignored in INIT; ignored requests SHALL NOT change any counter.
REQ-020 In IDLE, wr_en=1 at edge N SHALL store wdata at addr, set that entry's written flag, and increment wr_cnt.
REQ-021 In IDLE, rd_en=1 at edge N SHALL drive rdata=mem[addr] and rd_valid=1 after edge N (latency 1), and increment rd_cnt.
REQ-022 rd_valid SHALL be 1 for exactly one cycle per accepted read; back-to-back reads SHALL give back-to-back pulses.
REQ-023 rdata SHALL hold its last value when rd_valid=0.
REQ-024 rd_err SHALL equal the inverse of the read entry's written flag while rd_valid=1, and SHALL be 0 otherwise.
REQ-025 wr_en and rd_en together at different addresses SHALL both be performed in the same cycle.
REQ-026 wr_en and rd_en together at the same address SHALL follow REQ-033 or REQ-034.
REQ-027 wr_cnt and rd_cnt SHALL saturate at 255 and SHALL NOT wrap.

Reset
REQ-028 reset=1 at any edge SHALL force INIT with the init index at 0.
REQ-029 reset=1 SHALL force rdata=0, rd_valid=0, rd_err=0, busy=1, wr_cnt=0 and rd_cnt=0.
REQ-030 A read accepted on the cycle before reset SHALL be discarded; no rd_valid pulse SHALL appear after reset.
REQ-031 Reset asserted mid-INIT SHALL restart clearing from entry 0.

Configuration
REQ-032 Macro MEM_RD_BYPASS_EN SHALL select the same-address read/write collision behaviour.
REQ-033 With MEM_RD_BYPASS_EN defined, a same-address collision SHALL return the new wdata with rd_err=0.
REQ-034 Without MEM_RD_BYPASS_EN, a same-address collision SHALL return the old stored data, with rd_err from the old written flag; the write still SHALL complete.

Verification
REQ-035 Reset 1 cycle, then count cycles -> busy=1 for exactly 4 cycles; rd_en during INIT gives no rd_valid and rd_cnt=0.
REQ-036 Write 8'hA5 to addr 2, then read addr 2 -> rdata=8'hA5, rd_valid=1 one cycle after the read, rd_err=0, wr_cnt=1, rd_cnt=1.
REQ-037 Read unwritten addr 3 -> rdata=8'h00, rd_err=1 with rd_valid.
REQ-038 Write 8'h11 to addr 1, then same-cycle write 8'h22 and read addr 1 -> rdata=8'h22 with the macro, 8'h11 without it; a following read gives 8'h22.
REQ-039 Issue 300 writes -> wr_cnt=255; then assert reset with a read pending -> no rd_valid pulse, counters 0, all entries read back 8'h00 with rd_err=1.

Source files
------------

// File: rtl/mem_ctrl.sv
// Small synchronous memory controller: clears every entry after reset, then serves
// single-port reads/writes with per-entry written flags. `MEM_RD_BYPASS_EN` makes a same-cycle read return the new write data.
module mem_ctrl #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rd_valid,
    output logic                  rd_err,
    output logic                  busy,
    output logic [7:0]            wr_cnt,
    output logic [7:0]            rd_cnt
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {INIT, IDLE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   init_idx_q, init_idx_d;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]        written_q, written_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    rd_err_q, rd_err_d;
    logic [7:0]              wr_cnt_q, wr_cnt_d;
    logic [7:0]              rd_cnt_q, rd_cnt_d;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            init_idx_q <= '0;
            written_q  <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            written_q  <= written_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
        end
    end

    // Single write port shared by the init sweep and normal writes.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        rdata_d    = rdata_q;
        rd_valid_d = 1'b0;
        rd_err_d   = 1'b0;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        mem_we     = 1'b0;
        mem_waddr  = addr;
        mem_wdata  = wdata;
        if (state_q == INIT) begin
            mem_we     = 1'b1;
            mem_waddr  = init_idx_q;
            mem_wdata  = '0;
            init_idx_d = init_idx_q + ADDR_WIDTH'(1);
            if (init_idx_q == ADDR_WIDTH'(DEPTH - 1)) begin
                state_d = IDLE;
            end
        end else begin
            if (wr_en) begin
                mem_we = 1'b1;
                if (wr_cnt_q != 8'hFF) begin
                    wr_cnt_d = wr_cnt_q + 8'd1;
                end
            end
            if (rd_en) begin
                rd_valid_d = 1'b1;
                rdata_d    = mem[addr];
                rd_err_d   = ~written_q[addr];
`ifdef MEM_RD_BYPASS_EN
                // Reads and writes share addr, so any simultaneous write is a collision.
                if (wr_en) begin
                    rdata_d  = wdata;
                    rd_err_d = 1'b0;
                end
`endif
                if (rd_cnt_q != 8'hFF) begin
                    rd_cnt_d = rd_cnt_q + 8'd1;
                end
            end
        end
    end

    // Init sweep clears a flag, a normal write sets it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_written
            assign written_d[gi] = (mem_we && (mem_waddr == ADDR_WIDTH'(gi)))
                                   ? (state_q == IDLE) : written_q[gi];
        end
    endgenerate

    assign rdata    = rdata_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;
    assign busy     = (state_q == INIT);
    assign wr_cnt   = wr_cnt_q;
    assign rd_cnt   = rd_cnt_q;
endmodule
